// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing the single SRAM controller port between decoder masters.
// Owners may lock for bursts (capped under contention); read data is tagged back to its issuer.
module sram_port_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int READ_LATENCY = 2,
    parameter int MAX_BURST    = 16
) (
    input  logic                    Clock_50,
    input  logic                    Resetn,
    input  logic [NUM_REQ-1:0]      Req_i,
    input  logic [NUM_REQ-1:0]      Lock_i,
    input  logic [NUM_REQ-1:0]      We_n_i,
    input  logic [NUM_REQ*18-1:0]   Address_i,
    input  logic [NUM_REQ*16-1:0]   Write_data_i,
    output logic [NUM_REQ-1:0]      Grant_o,
    output logic [17:0]             SRAM_address_o,
    output logic [15:0]             SRAM_write_data_o,
    output logic                    SRAM_we_n_o,
    input  logic [15:0]             SRAM_read_data_i,
    output logic [15:0]             Read_data_o,
    output logic [NUM_REQ-1:0]      Read_valid_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {S_ARB, S_OWN} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [17:0]         addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                we_n_q, we_n_d;
    logic                iss_rd_q, iss_rd_d;
    logic [IW-1:0]       iss_idx_q, iss_idx_d;
    logic                pipe_rd_q  [READ_LATENCY];
    logic                pipe_rd_d  [READ_LATENCY];
    logic [IW-1:0]       pipe_idx_q [READ_LATENCY];
    logic [IW-1:0]       pipe_idx_d [READ_LATENCY];

    logic                win_found;
    logic [IW-1:0]       win_idx;
    logic [IW-1:0]       cand;
    logic                accept;
    logic                others;
    logic                release_own;
    logic [CW-1:0]       cnt_inc;

    // Round-robin search starting just after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = '0;
        for (int j = 1; j <= NUM_REQ; j++) begin
            cand = IW'((int'(ptr_q) + j) % NUM_REQ);
            if (!win_found && Req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign accept  = (state_q == S_OWN) && grant_q[ptr_q] && Req_i[ptr_q];
    assign others  = |(Req_i & ~grant_q);
    assign cnt_inc = (cnt_q == CW'(MAX_BURST)) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_n_d      = 1'b1;
        iss_rd_d    = 1'b0;
        iss_idx_d   = ptr_q;
        release_own = 1'b0;

        case (state_q)
            S_ARB: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    ptr_d            = win_idx;
                    cnt_d            = '0;
                    state_d          = S_OWN;
                end
            end
            S_OWN: begin
                if (accept) begin
                    addr_d   = Address_i[ptr_q*18 +: 18];
                    wdata_d  = Write_data_i[ptr_q*16 +: 16];
                    we_n_d   = We_n_i[ptr_q];
                    iss_rd_d = We_n_i[ptr_q];
                    cnt_d    = cnt_inc;
                end
                release_own = !Req_i[ptr_q]
                           || (!Lock_i[ptr_q] && others)
                           || ((cnt_d == CW'(MAX_BURST)) && others);
                // Releasing always passes through one idle S_ARB cycle.
                if (release_own) begin
                    grant_d = '0;
                    state_d = S_ARB;
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_ARB;
            end
        endcase

        pipe_rd_d[0]  = iss_rd_q;
        pipe_idx_d[0] = iss_idx_q;
        for (int j = 1; j < READ_LATENCY; j++) begin
            pipe_rd_d[j]  = pipe_rd_q[j-1];
            pipe_idx_d[j] = pipe_idx_q[j-1];
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= S_ARB;
            ptr_q     <= IW'(NUM_REQ - 1);
            grant_q   <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_n_q    <= 1'b1;
            iss_rd_q  <= 1'b0;
            iss_idx_q <= '0;
            for (int j = 0; j < READ_LATENCY; j++) begin
                pipe_rd_q[j]  <= 1'b0;
                pipe_idx_q[j] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_n_q    <= we_n_d;
            iss_rd_q  <= iss_rd_d;
            iss_idx_q <= iss_idx_d;
            for (int j = 0; j < READ_LATENCY; j++) begin
                pipe_rd_q[j]  <= pipe_rd_d[j];
                pipe_idx_q[j] <= pipe_idx_d[j];
            end
        end
    end

    // The tag leaving the pipe lines up with data arriving from the controller.
    always_comb begin
        Read_valid_o = '0;
        if (pipe_rd_q[READ_LATENCY-1]) begin
            Read_valid_o[pipe_idx_q[READ_LATENCY-1]] = 1'b1;
        end
    end

    assign Grant_o           = grant_q;
    assign SRAM_address_o    = addr_q;
    assign SRAM_write_data_o = wdata_q;
    assign SRAM_we_n_o       = we_n_q;
    assign Read_data_o       = SRAM_read_data_i;

endmodule
